alu_frame_sender: RTL and testbench

ALU_FRAME_SENDER -- requirements
Module: alu_frame_sender

---
 rtl/alu_frame_pkg.sv | 36 +++
 rtl/alu_frame_sender_rise_detect.sv | 20 ++
 rtl/alu_frame_sender.sv | 158 +++++++++++++++
 tb/tb_alu_frame_sender.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_frame_pkg.sv
// Shared definitions for the ALU frame link: FSM encoding, opcode set and the
// ASCII operator bytes that the receiving side decodes.
package alu_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_WAIT_RX = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OPC_ADD = 2'd0,
    OPC_SUB = 2'd1,
    OPC_AND = 2'd2,
    OPC_OR  = 2'd3
  } opc_e;

  localparam logic [7:0] ASCII_ADD = 8'd43;   // '+'
  localparam logic [7:0] ASCII_SUB = 8'd45;   // '-'
  localparam logic [7:0] ASCII_AND = 8'd38;   // '&'
  localparam logic [7:0] ASCII_OR  = 8'd124;  // '|'

  // Operator character carried in the middle byte of a frame.
  function automatic logic [7:0] op_char(input logic [1:0] opc);
    case (opc_e'(opc))
      OPC_ADD: op_char = ASCII_ADD;
      OPC_SUB: op_char = ASCII_SUB;
      OPC_AND: op_char = ASCII_AND;
      default: op_char = ASCII_OR;
    endcase
  endfunction

endpackage

// File: rtl/alu_frame_sender_rise_detect.sv
// Rising-edge detector: one-cycle pulse on a 0->1 transition of a level input.
// A level held high produces a single pulse.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic prev_q;

  // Remember last cycle's level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) prev_q <= 1'b0;
    else       prev_q <= i_sig;
  end

  assign o_rise = i_sig & ~prev_q;

endmodule

// File: rtl/alu_frame_sender.sv
// ALU frame sender: latches two operands and an opcode, streams the 3-byte
// frame {a, op_char, b} to a UART transmitter, then waits for a one-byte
// response from the UART receiver and presents it on o_result/o_valid.
// Optional feature macro: ALU_FRAME_TIMEOUT_EN adds a response timeout and
// the o_timeout pulse output.
module alu_frame_sender
  import alu_frame_pkg::*;
#(
  parameter int NB_BITS        = 8,
  parameter int NB_OPC         = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_BITS-1:0] i_data_a,
  input  logic [NB_BITS-1:0] i_data_b,
  input  logic [NB_OPC-1:0]  i_opc,
  output logic [NB_BITS-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic [NB_BITS-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_BITS-1:0] o_result,
  output logic               o_valid,
  output logic               o_busy
`ifdef ALU_FRAME_TIMEOUT_EN
  ,
  output logic               o_timeout
`endif
);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [NB_BITS-1:0] a_q, a_d, b_q, b_d;
  logic [NB_OPC-1:0]  opc_q, opc_d;
  logic [NB_BITS-1:0] tx_data_q, tx_data_d;
  logic [NB_BITS-1:0] result_q, result_d;
  logic               tx_rise, rx_rise;
  logic [NB_BITS-1:0] next_byte;

`ifdef ALU_FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rise_detect u_tx_rise (.i_clk(i_clk), .i_rst(i_rst), .i_sig(i_tx_done), .o_rise(tx_rise));
  rise_detect u_rx_rise (.i_clk(i_clk), .i_rst(i_rst), .i_sig(i_rx_done), .o_rise(rx_rise));

  // Byte that follows the current index in the frame (index 0 is loaded from IDLE).
  always_comb begin
    next_byte = b_q;
    if (idx_q == 2'd0) next_byte = NB_BITS'(op_char(opc_q[1:0]));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    opc_d     = opc_q;
    tx_data_d = tx_data_q;
    result_d  = result_q;
`ifdef ALU_FRAME_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          a_d       = i_data_a;
          b_d       = i_data_b;
          opc_d     = i_opc;
          idx_d     = 2'd0;
          tx_data_d = i_data_a;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD:    state_d = ST_SEND;
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_rise) begin
          if (idx_q < 2'd2) begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = next_byte;
            state_d   = ST_LOAD;
          end else begin
            state_d = ST_WAIT_RX;
          end
        end
      end
      ST_WAIT_RX: begin
        if (rx_rise) begin
          result_d = i_rx_data;
          state_d  = ST_DONE;
        end
`ifdef ALU_FRAME_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
`ifdef ALU_FRAME_TIMEOUT_EN
    // Counter only lives while waiting for the response.
    if (state_d != ST_WAIT_RX) cnt_d = '0;
`endif
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      opc_q     <= '0;
      tx_data_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opc_q     <= opc_d;
      tx_data_q <= tx_data_d;
      result_q  <= result_d;
    end
  end

`ifdef ALU_FRAME_TIMEOUT_EN
  // Response timeout counter and its one-cycle pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`endif

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = (state_q == ST_SEND);
  assign o_result   = result_q;
  assign o_valid    = (state_q == ST_DONE);
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_frame_sender.sv
// Scoreboard bench for alu_frame_sender: expected tx bytes and responses are
// queued when a frame is launched and popped by a monitor as the DUT emits them.
module tb_alu_frame_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_data_a, i_data_b;
  logic [1:0] i_opc;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_done;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [7:0] o_result;
  logic       o_valid;
  logic       o_busy;
`ifdef ALU_FRAME_TIMEOUT_EN
  logic       o_timeout;
`endif

  alu_frame_sender #(.NB_BITS(8), .NB_OPC(2), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_opc(i_opc),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_result(o_result), .o_valid(o_valid), .o_busy(o_busy)
`ifdef ALU_FRAME_TIMEOUT_EN
    , .o_timeout(o_timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_txs = 0, n_valid = 0;
  logic [7:0] tx_q[$];
  logic [7:0] res_q[$];
  logic [7:0] last_res = 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] op_byte(input logic [1:0] op);
    case (op)
      2'd0: op_byte = 8'd43;
      2'd1: op_byte = 8'd45;
      2'd2: op_byte = 8'd38;
      default: op_byte = 8'd124;
    endcase
  endfunction

  // Monitor: every tx start and every valid pulse must match a queued entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_tx_start) begin
        n_txs++;
        if (tx_q.size() > 0) chk("tx_byte", o_tx_data, tx_q.pop_front());
        else                 chk("tx_unexpected", 1, 0);
      end
      if (o_valid) begin
        n_valid++;
        if (res_q.size() > 0) chk("result", o_result, res_q.pop_front());
        else                  chk("valid_unexpected", 1, 0);
      end
    end
  end

  task automatic wait_txs(input int target);
    for (int i = 0; i < 60; i++) begin
      if (n_txs >= target) return;
      @(negedge clk); #1;
    end
    chk("tx_start_wait", n_txs, target);
  endtask

  // Launch a frame from IDLE and check the 2-clock start latency.
  task automatic start_frame(input logic [7:0] a, b, input logic [1:0] op, output int base);
    @(negedge clk);
    base = n_txs;
    i_data_a = a; i_data_b = b; i_opc = op; i_start = 1'b1;
    tx_q.push_back(a); tx_q.push_back(op_byte(op)); tx_q.push_back(b);
    @(negedge clk);
    chk("load_byte", o_tx_data, a);
    chk("lat_load_no_start", o_tx_start, 0);
    i_start = 1'b0;
    i_data_a = 8'($urandom); i_data_b = 8'($urandom); i_opc = 2'($urandom);
    @(negedge clk);
    chk("lat_send_start", o_tx_start, 1);
  endtask

  // Play the UART side: acknowledge each byte, then optionally respond.
  task automatic serve(input int base, input logic [7:0] a, b, input logic [1:0] op,
                       input logic [7:0] resp, input int hold, input bit inject, input bit respond);
    logic [7:0] exp;
    int vbase;
    vbase = n_valid;
    for (int k = 0; k < 3; k++) begin
      wait_txs(base + k + 1);
      exp = (k == 0) ? a : (k == 1) ? op_byte(op) : b;
      repeat (2) @(negedge clk);
      chk("tx_stable", o_tx_data, exp);
      if (inject && k == 0) begin
        i_rx_data = 8'hEE; i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        @(negedge clk);
        chk("rx_ignored", o_result, last_res);
      end
      i_tx_done = 1'b1;
      repeat (hold) @(negedge clk);
      i_tx_done = 1'b0;
      @(negedge clk);
    end
    chk("tx_count", n_txs - base, 3);
    if (!respond) return;
    repeat (2) @(negedge clk);
    i_rx_data = resp; res_q.push_back(resp); i_rx_done = 1'b1;
    @(negedge clk); #1;
    i_rx_done = 1'b0;
    for (int i = 0; i < 20 && n_valid == vbase; i++) begin @(negedge clk); #1; end
    chk("valid_count", n_valid - vbase, 1);
    last_res = resp;
  endtask

  initial begin
    int base;
    logic [7:0] ra, rb, rr;
    logic [1:0] ro;
    rst = 1'b1; i_start = 1'b0; i_data_a = '0; i_data_b = '0; i_opc = '0;
    i_tx_done = 1'b0; i_rx_data = '0; i_rx_done = 1'b0;
    #1;
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_tx_start", o_tx_start, 0);
    chk("rst_result", o_result, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic ADD frame: 0x03 '+' 0x05, response 0x08.
    start_frame(8'h03, 8'h05, 2'd0, base);
    serve(base, 8'h03, 8'h05, 2'd0, 8'h08, 1, 1'b0, 1'b1);
    @(negedge clk);
    chk("idle_after_done", o_busy, 0);
    chk("result_held", o_result, 8'h08);

    // tx_done held high for 10 cycles counts once.
    start_frame(8'hA5, 8'h5A, 2'd1, base);
    serve(base, 8'hA5, 8'h5A, 2'd1, 8'h4B, 10, 1'b0, 1'b1);

    // rx_done pulse during WAIT_TX is ignored.
    start_frame(8'h0F, 8'hF0, 2'd2, base);
    serve(base, 8'h0F, 8'hF0, 2'd2, 8'h00, 2, 1'b1, 1'b1);

    // Reset in WAIT_TX after byte 1 aborts the frame.
    start_frame(8'h12, 8'h34, 2'd0, base);
    wait_txs(base + 1);
    repeat (2) @(negedge clk);
    i_tx_done = 1'b1; @(negedge clk); i_tx_done = 1'b0;
    wait_txs(base + 2);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_tx_data", o_tx_data, 0);
    chk("arst_tx_start", o_tx_start, 0);
    chk("arst_result", o_result, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_busy", o_busy, 0);
    tx_q.delete(); res_q.delete(); last_res = 8'h00;
    base = n_txs;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_tx_after_reset", n_txs - base, 0);
    chk("idle_after_reset", o_busy, 0);

    // i_start held high, OR opcode: back-to-back frames, each from IDLE.
    @(negedge clk);
    base = n_txs;
    i_data_a = 8'h11; i_data_b = 8'h22; i_opc = 2'd3; i_start = 1'b1;
    for (int f = 0; f < 2; f++) begin
      tx_q.push_back(8'h11); tx_q.push_back(8'd124); tx_q.push_back(8'h22);
    end
    serve(base, 8'h11, 8'h22, 2'd3, 8'h33, 1, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_idle_gap", o_busy, 0);
    serve(base + 3, 8'h11, 8'h22, 2'd3, 8'h44, 1, 1'b0, 1'b1);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_stops", o_busy, 0);

    // A few random frames.
    for (int r = 0; r < 3; r++) begin
      ra = 8'($urandom); rb = 8'($urandom); ro = 2'($urandom); rr = 8'($urandom);
      start_frame(ra, rb, ro, base);
      serve(base, ra, rb, ro, rr, 1 + r, 1'b0, 1'b1);
    end

`ifdef ALU_FRAME_TIMEOUT_EN
    // No response: timeout 16 cycles after WAIT_RX entry, result unchanged.
    start_frame(8'h01, 8'h02, 2'd0, base);
    for (int k = 0; k < 3; k++) begin
      wait_txs(base + k + 1);
      repeat (2) @(negedge clk);
      i_tx_done = 1'b1;
      if (k < 2) begin @(negedge clk); i_tx_done = 1'b0; end
    end
    repeat (15) @(negedge clk);
    i_tx_done = 1'b0;
    chk("timeout_early", o_timeout, 0);
    chk("busy_in_wait_rx", o_busy, 1);
    @(negedge clk);
    chk("timeout_pulse", o_timeout, 1);
    chk("timeout_idle", o_busy, 0);
    chk("timeout_result", o_result, last_res);
    @(negedge clk);
    chk("timeout_one_cycle", o_timeout, 0);
`endif

    repeat (5) @(negedge clk);
    chk("tx_queue_empty", tx_q.size(), 0);
    chk("res_queue_empty", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
